ud_counter_bank: RTL

UD_COUNTER_BANK -- requirements
Module: ud_counter_bank

---
 rtl/udc_pkg.sv | 22 ++
 rtl/udc_channel.sv | 143 ++++++++++++++
 rtl/ud_counter_bank.sv | 104 ++++++++++
 3 files changed

// File: rtl/udc_pkg.sv
// rtl/udc_pkg.sv - mode encoding, register offsets and CTRL bit positions for ud_counter_bank
package udc_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } udc_mode_e;

  localparam logic [1:0] REG_LOAD  = 2'd0;
  localparam logic [1:0] REG_LIMIT = 2'd1;
  localparam logic [1:0] REG_STEP  = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_AUTO   = 3;
  localparam int CTRL_STOP   = 4;
  localparam int CTRL_ERRCLR = 7;

endpackage

// File: rtl/udc_channel.sv
// rtl/udc_channel.sv - one clamped up/down/bounce counter channel with its LOAD/LIMIT/STEP/CTRL registers
module udc_channel
  import udc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       wr_sel_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] count_o,
  output logic             dir_o,
  output logic             ec_o,
  output logic             reject_o,
  output logic [WIDTH-1:0] load_o,
  output logic [WIDTH-1:0] limit_o,
  output logic [WIDTH-1:0] step_o
);

  logic [WIDTH-1:0] load_q, load_d, limit_q, limit_d, step_q, step_d;
  logic [WIDTH-1:0] act_load_q, act_load_d, act_limit_q, act_limit_d, act_step_q, act_step_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             en_q, en_d, auto_q, auto_d, run_q, run_d, dir_q, dir_d, ec_q, ec_d;
  udc_mode_e        mode_q, mode_d, act_mode_q, act_mode_d, chk_mode;

  logic             stop, launch, reload, cfg_ok, hit;
  logic [WIDTH-1:0] lo_bound, up_val, dn_val, step_val, bound;

  assign stop   = wr_sel_i[REG_CTRL] && wdata_i[CTRL_STOP];
  assign launch = start_i && en_q;
  assign reload = run_q && ec_q && auto_q && (act_mode_q != MODE_BOUNCE);

  // A reload revalidates against the running mode, since LOAD/LIMIT/STEP may have been rewritten.
  assign chk_mode = launch ? mode_q : act_mode_q;
  assign cfg_ok   = (step_q != '0) && (chk_mode != MODE_RSVD) &&
                    ((chk_mode == MODE_DOWN) ? (limit_q <= load_q) : (limit_q >= load_q));

  // Compare remaining distance against STEP so a step clamps at the bound and never wraps.
  assign lo_bound = (act_mode_q == MODE_DOWN) ? act_limit_q : act_load_q;
  assign up_val   = ((act_limit_q - count_q) < act_step_q) ? act_limit_q : count_q + act_step_q;
  assign dn_val   = ((count_q - lo_bound) < act_step_q) ? lo_bound : count_q - act_step_q;
  assign step_val = dir_q ? up_val : dn_val;
  assign bound    = dir_q ? act_limit_q : lo_bound;
  assign hit      = (step_val == bound);

  always_comb begin
    load_d      = load_q;
    limit_d     = limit_q;
    step_d      = step_q;
    en_d        = en_q;
    mode_d      = mode_q;
    auto_d      = auto_q;
    act_load_d  = act_load_q;
    act_limit_d = act_limit_q;
    act_step_d  = act_step_q;
    act_mode_d  = act_mode_q;
    count_d     = count_q;
    run_d       = run_q;
    dir_d       = dir_q;
    ec_d        = 1'b0;
    reject_o    = 1'b0;

    if (wr_sel_i[REG_LOAD])  load_d  = wdata_i;
    if (wr_sel_i[REG_LIMIT]) limit_d = wdata_i;
    if (wr_sel_i[REG_STEP])  step_d  = wdata_i;
    if (wr_sel_i[REG_CTRL]) begin
      en_d   = wdata_i[CTRL_EN];
      mode_d = udc_mode_e'(wdata_i[CTRL_MODE +: 2]);
      auto_d = wdata_i[CTRL_AUTO];
    end

    if (stop) begin
      run_d = 1'b0;
    end else if (launch || reload) begin
      if (cfg_ok) begin
        run_d       = 1'b1;
        count_d     = load_q;
        act_load_d  = load_q;
        act_limit_d = limit_q;
        act_step_d  = step_q;
        ec_d        = (load_q == limit_q);
        if (launch) begin
          act_mode_d = mode_q;
          dir_d      = (mode_q != MODE_DOWN);
        end
      end else begin
        run_d    = 1'b0;
        reject_o = 1'b1;
      end
    end else if (run_q) begin
      if (ec_q && (act_mode_q != MODE_BOUNCE)) begin
        run_d = 1'b0;
      end else begin
        count_d = step_val;
        ec_d    = hit;
        if (hit && (act_mode_q == MODE_BOUNCE)) dir_d = ~dir_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      load_q      <= '0;
      limit_q     <= '0;
      step_q      <= '0;
      en_q        <= 1'b0;
      mode_q      <= MODE_UP;
      auto_q      <= 1'b0;
      act_load_q  <= '0;
      act_limit_q <= '0;
      act_step_q  <= '0;
      act_mode_q  <= MODE_UP;
      count_q     <= '0;
      run_q       <= 1'b0;
      dir_q       <= 1'b1;
      ec_q        <= 1'b0;
    end else begin
      load_q      <= load_d;
      limit_q     <= limit_d;
      step_q      <= step_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      auto_q      <= auto_d;
      act_load_q  <= act_load_d;
      act_limit_q <= act_limit_d;
      act_step_q  <= act_step_d;
      act_mode_q  <= act_mode_d;
      count_q     <= count_d;
      run_q       <= run_d;
      dir_q       <= dir_d;
      ec_q        <= ec_d;
    end
  end

  assign count_o = count_q;
  assign dir_o   = dir_q;
  assign ec_o    = ec_q;
  assign load_o  = load_q;
  assign limit_o = limit_q;
  assign step_o  = step_q;

endmodule

// File: rtl/ud_counter_bank.sv
// rtl/ud_counter_bank.sv - bank of NCH counters with strobe bus and sticky err; UDC_READBACK_EN enables reads
module ud_counter_bank
  import udc_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NCH    = 2,
  localparam int ADDR_W = $clog2(NCH) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 ncs,
  input  logic                 nwr,
  input  logic                 nrd,
  input  logic                 start,
  inout  wire  [WIDTH-1:0]     din,
  output logic [NCH*WIDTH-1:0] cout,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       ec,
  output logic                 err
);

  localparam logic [ADDR_W-1:0] NCH_A = ADDR_W'(NCH);

  logic                      wr_en, rd_en, bus_clash, chan_ok, ctrl_wr, new_err, err_q, err_d;
  logic [1:0]                reg_sel;
  logic [ADDR_W-1:0]         chan_idx;
  logic [NCH-1:0]            reject;
  logic [NCH-1:0][WIDTH-1:0] load_p, limit_p, step_p, count_p;

  assign wr_en     = !ncs && !nwr && nrd;
  assign rd_en     = !ncs && !nrd && nwr;
  assign bus_clash = !ncs && !nwr && !nrd;
  assign reg_sel   = addr[1:0];
  assign chan_idx  = addr >> 2;
  assign chan_ok   = (chan_idx < NCH_A);
  assign ctrl_wr   = wr_en && chan_ok && (reg_sel == REG_CTRL);

  assign new_err = bus_clash || (wr_en && !chan_ok) ||
                   (ctrl_wr && (din[CTRL_MODE +: 2] == MODE_RSVD)) || (|reject);

  // A fresh error outranks ERRCLR arriving on the same edge.
  always_comb begin
    err_d = err_q;
    if (new_err)                          err_d = 1'b1;
    else if (ctrl_wr && din[CTRL_ERRCLR]) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic       sel;
    logic [3:0] wr_sel;
    assign sel    = wr_en && (chan_idx == ADDR_W'(k));
    assign wr_sel = {4{sel}} & (4'b0001 << reg_sel);

    udc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_sel_i (wr_sel),
      .wdata_i  (din),
      .start_i  (start),
      .count_o  (count_p[k]),
      .dir_o    (dir[k]),
      .ec_o     (ec[k]),
      .reject_o (reject[k]),
      .load_o   (load_p[k]),
      .limit_o  (limit_p[k]),
      .step_o   (step_p[k])
    );
  end

  assign cout = count_p;

`ifdef UDC_READBACK_EN
  logic [WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (chan_idx == ADDR_W'(k)) begin
        case (reg_sel)
          REG_LOAD:  rdata = load_p[k];
          REG_LIMIT: rdata = limit_p[k];
          REG_STEP:  rdata = step_p[k];
          default:   rdata = count_p[k];
        endcase
      end
    end
  end

  assign din = rd_en ? rdata : {WIDTH{1'bz}};
`else
  logic unused_rb;
  assign unused_rb = ^{rd_en, load_p, limit_p, step_p};
  assign din       = {WIDTH{1'bz}};
`endif

endmodule
